// File: rtl/mult_radix_seq_if.sv
// Operand/result handshake bundle for mult_radix_seq.
// in_signed exists only when MULT_SIGNED_EN is defined.
interface mult_radix_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic [DATA_WIDTH-1:0]   in_mult_a;
  logic [DATA_WIDTH-1:0]   in_mult_b;
`ifdef MULT_SIGNED_EN
  logic                    in_signed;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] out_mult_result;

  modport master (
`ifdef MULT_SIGNED_EN
    output in_signed,
`endif
    output in_valid, in_mode, in_mult_a, in_mult_b, out_ready,
    input  in_ready, out_valid, out_mult_result
  );

  modport slave (
`ifdef MULT_SIGNED_EN
    input  in_signed,
`endif
    input  in_valid, in_mode, in_mult_a, in_mult_b, out_ready,
    output in_ready, out_valid, out_mult_result
  );
endinterface

// File: rtl/mult_radix_seq.sv
// Digit-serial integer / carry-less multiplier, DIGIT_WIDTH multiplier bits per cycle.
// Optional macro MULT_SIGNED_EN adds two's-complement integer multiply (in_signed).
module mult_radix_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 1
) (
  input logic             clk,
  input logic             rst,
  mult_radix_seq_if.slave bus
);
  localparam int STEPS = DATA_WIDTH / DIGIT_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_digit
    $error("mult_radix_seq: DIGIT_WIDTH must divide DATA_WIDTH");
  end

  logic [1:0]            state;
  logic [CNT_W-1:0]      step;
  logic [PW-1:0]         a_sh;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         pp;
  logic [DATA_WIDTH-1:0] b_sh;
  logic                  mode_r;
  logic                  neg_r;
  logic                  sgn_in;
  logic                  accept;
  logic                  last;
  logic                  done;

  // Partial product of one digit; the signed final digit weights its MSB negatively.
  function automatic logic [PW-1:0] partial(input logic [PW-1:0]          a_val,
                                            input logic [DIGIT_WIDTH-1:0] d,
                                            input logic                   clmul,
                                            input logic                   neg_msb);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGIT_WIDTH; i++) begin
      if (d[i]) begin
        if (clmul)                              r = r ^ (a_val << i);
        else if (neg_msb && i == DIGIT_WIDTH-1) r = r - (a_val << i);
        else                                    r = r + (a_val << i);
      end
    end
    return r;
  endfunction

`ifdef MULT_SIGNED_EN
  assign sgn_in = bus.in_signed && !bus.in_mode;
`else
  assign sgn_in = 1'b0;
`endif

  assign done                = (state == DONE) && !rst;
  assign bus.in_ready        = (state == IDLE) && !rst;
  assign bus.out_valid       = done;
  assign bus.out_mult_result = done ? acc : '0;

  assign accept = bus.in_valid && (state == IDLE) && !rst;
  assign last   = (step == CNT_W'(STEPS - 1));
  assign pp     = partial(a_sh, b_sh[DIGIT_WIDTH-1:0], mode_r, neg_r && last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          step  <= '0;
        end
        RUN: begin
          if (last) state <= DONE;
          else      step  <= step + CNT_W'(1);
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          step  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Multiplicand shifts left and multiplier right so each step sees its digit at bit 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh   <= {{DATA_WIDTH{sgn_in & bus.in_mult_a[DATA_WIDTH-1]}}, bus.in_mult_a};
      b_sh   <= bus.in_mult_b;
      mode_r <= bus.in_mode;
      neg_r  <= sgn_in;
      acc    <= '0;
    end else if (state == RUN) begin
      acc  <= mode_r ? (acc ^ pp) : (acc + pp);
      a_sh <= a_sh << DIGIT_WIDTH;
      b_sh <= b_sh >> DIGIT_WIDTH;
    end
  end
endmodule

// File: tb/tb_mult_radix_seq.sv
// Bench for mult_radix_seq: an 8-bit/radix-4 instance checked every cycle against a
// transaction-level model, plus a 32-bit/radix-2 instance for latency and throughput.
module tb_mult_radix_seq;
  localparam int STEPS8  = 4;
  localparam int STEPS32 = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic s8 = 1'b0;
  logic s32 = 1'b0;

  bit          m_active = 1'b0;
  int          m_valid_at = 0;
  logic [63:0] m_res = '0;
  bit          exp_v;
  bit          exp_r;

  mult_radix_seq_if #(.DATA_WIDTH(8))  bus8();
  mult_radix_seq_if #(.DATA_WIDTH(32)) bus32();

  mult_radix_seq #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  mult_radix_seq #(.DATA_WIDTH(32), .DIGIT_WIDTH(1)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product from plain arithmetic on w-bit operands.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit mode, input bit sgn, input int w);
    logic [63:0] r, mask, sa, sb;
    r    = '0;
    mask = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    if (mode) begin
      for (int i = 0; i < w; i++) if (b[i]) r = r ^ (64'(a) << i);
    end else if (sgn) begin
      sa = 64'(a);
      sb = 64'(b);
      if (a[w-1]) sa = sa | ~((64'd1 << w) - 64'd1);
      if (b[w-1]) sb = sb | ~((64'd1 << w) - 64'd1);
      r = sa * sb;
    end else begin
      r = 64'(a) * 64'(b);
    end
    return r & mask;
  endfunction

  // Per-cycle compare of the 8-bit instance, then predict the next edge.
  always @(negedge clk) begin
    exp_v = !rst && m_active && (cyc >= m_valid_at);
    exp_r = !rst && !m_active;
    chk("out_valid8", 64'(bus8.out_valid), 64'(exp_v));
    chk("in_ready8", 64'(bus8.in_ready), 64'(exp_r));
    if (exp_v || rst) chk("result8", 64'(bus8.out_mult_result), exp_v ? m_res : 64'd0);
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (bus8.in_valid) begin
        m_active   = 1'b1;
        m_res      = model(32'(bus8.in_mult_a), 32'(bus8.in_mult_b), bus8.in_mode, s8, 8);
        m_valid_at = cyc + 1 + STEPS8;
      end
    end else if (cyc >= m_valid_at && bus8.out_ready) begin
      m_active = 1'b0;
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit mode, input bit sgn);
    int n;
    @(posedge clk); #1;
    bus8.in_mult_a = a;
    bus8.in_mult_b = b;
    bus8.in_mode   = mode;
    s8             = sgn;
`ifdef MULT_SIGNED_EN
    bus8.in_signed = sgn;
`endif
    bus8.in_valid  = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus8.in_ready) break;
    end
    if (n == 100) chk("accept8 timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.out_valid && n < 200);
    if (!bus8.out_valid) chk("valid8 timeout", 64'd0, 64'd1);
  endtask

  task automatic consume8();
    @(posedge clk); #1;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input bit mode, input bit sgn);
    int n;
    @(posedge clk); #1;
    bus32.in_mult_a = a;
    bus32.in_mult_b = b;
    bus32.in_mode   = mode;
    s32             = sgn;
`ifdef MULT_SIGNED_EN
    bus32.in_signed = sgn;
`endif
    bus32.in_valid  = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus32.in_ready) break;
    end
    if (n == 100) chk("accept32 timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic wait_valid32(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus32.out_valid && n < 200);
    if (!bus32.out_valid) chk("valid32 timeout", 64'd0, 64'd1);
  endtask

  task automatic consume32();
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [63:0] r;
    logic [31:0] a, b;
    bit          md, sg;
    int          q[$];

    bus8.in_valid = 1'b0;  bus8.in_mode = 1'b0;  bus8.in_mult_a = '0;  bus8.in_mult_b = '0;
    bus8.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_mode = 1'b0; bus32.in_mult_a = '0; bus32.in_mult_b = '0;
    bus32.out_ready = 1'b0;
`ifdef MULT_SIGNED_EN
    bus8.in_signed = 1'b0;
    bus32.in_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(bus8.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus8.out_valid), 64'd0);
    chk("reset in_ready32", 64'(bus32.in_ready), 64'd1);

    chk("model int", model(32'hFF, 32'hFF, 1'b0, 1'b0, 8), 64'hFE01);
    chk("model clmul", model(32'h53, 32'hCA, 1'b1, 1'b0, 8), 64'h3F7E);
    chk("model signed", model(32'hFF, 32'h02, 1'b0, 1'b1, 8), 64'hFFFE);
    chk("model int32", model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32), 64'hFFFFFFFE00000001);

    // Integer multiply and its latency.
    send8(8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_valid8(n);
    chk("t1 latency", 64'(n), 64'd5);
    chk("t1 result", 64'(bus8.out_mult_result), 64'hFE01);
    consume8();
    chk("t1 in_ready after", 64'(bus8.in_ready), 64'd1);

    // Carry-less multiply, top bit always clear.
    send8(8'h53, 8'hCA, 1'b1, 1'b0);
    bus8.in_mult_a = 8'h00;
    bus8.in_mode   = 1'b0;
    wait_valid8(n);
    chk("t2 result", 64'(bus8.out_mult_result), 64'h3F7E);
    chk("t2 bit15", 64'(bus8.out_mult_result[15]), 64'd0);
    consume8();

    // Backpressure with an ignored second request.
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid8(n);
    r = 64'(bus8.out_mult_result);
    chk("t3 result", r, 64'h03A8);
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.in_mult_a = 8'h77; bus8.in_mult_b = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t3 stable", 64'(bus8.out_mult_result), 64'h03A8);
      chk("t3 valid held", 64'(bus8.out_valid), 64'd1);
      chk("t3 in_ready low", 64'(bus8.in_ready), 64'd0);
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3 in_ready next", 64'(bus8.in_ready), 64'd1);
    chk("t3 valid dropped", 64'(bus8.out_valid), 64'd0);
    bus8.out_ready = 1'b0;

    // Reset during RUN aborts; next operation starts clean.
    send8(8'hFF, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4 no valid", 64'(bus8.out_valid), 64'd0);
    end
    send8(8'h00, 8'hAB, 1'b0, 1'b0);
    wait_valid8(n);
    chk("t4 latency", 64'(n), 64'd5);
    chk("t4 result", 64'(bus8.out_mult_result), 64'h0000);
    consume8();

`ifdef MULT_SIGNED_EN
    send8(8'hFF, 8'h02, 1'b0, 1'b1);
    wait_valid8(n);
    chk("t5 signed", 64'(bus8.out_mult_result), 64'hFFFE);
    consume8();
    send8(8'hFF, 8'h02, 1'b0, 1'b0);
    wait_valid8(n);
    chk("t5 unsigned", 64'(bus8.out_mult_result), 64'h01FE);
    consume8();
    send8(8'hFF, 8'h02, 1'b1, 1'b1);
    wait_valid8(n);
    chk("t5 clmul ignores signed", 64'(bus8.out_mult_result), 64'h01FE);
    consume8();
`endif

    // Random traffic, backpressure and occasional reset, checked by the compare process.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      bus8.in_valid  = ($urandom % 3) != 0;
      bus8.in_mult_a = 8'($urandom);
      bus8.in_mult_b = 8'($urandom);
      bus8.in_mode   = 1'($urandom);
`ifdef MULT_SIGNED_EN
      s8             = 1'($urandom);
      bus8.in_signed = s8;
`endif
      bus8.out_ready = ($urandom % 4) != 0;
      rst            = ($urandom % 150) == 0;
    end
    @(posedge clk); #1;
    rst = 1'b0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 bus8.out_ready = 1'b0;

    // Wide instance: latency, random operands, and back-to-back spacing.
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_valid32(n);
    chk("t6 latency", 64'(n), 64'd33);
    chk("t6 result", bus32.out_mult_result, 64'hFFFFFFFE00000001);
    consume32();
    for (int i = 0; i < 6; i++) begin
      a  = $urandom;
      b  = $urandom;
      md = 1'($urandom);
`ifdef MULT_SIGNED_EN
      sg = 1'($urandom);
`else
      sg = 1'b0;
`endif
      send32(a, b, md, sg);
      wait_valid32(n);
      chk("rand32 latency", 64'(n), 64'(STEPS32 + 1));
      chk("rand32 result", bus32.out_mult_result, model(a, b, md, sg && !md, 32));
      consume32();
    end
    @(posedge clk); #1;
    bus32.in_mult_a = 32'h1234; bus32.in_mult_b = 32'h5678; bus32.in_mode = 1'b0;
`ifdef MULT_SIGNED_EN
    bus32.in_signed = 1'b0;
`endif
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    for (int i = 0; i < 200 && q.size() < 3; i++) begin
      @(negedge clk);
      if (bus32.in_ready) q.push_back(cyc);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    chk("t6 accept count", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      chk("t6 spacing 1", 64'(q[1] - q[0]), 64'd34);
      chk("t6 spacing 2", 64'(q[2] - q[1]), 64'd34);
    end
    repeat (40) @(posedge clk);
    #1 bus32.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
